seg7_scan_controller: RTL and testbench
=======================================

SEG7_SCAN_CONTROLLER -- requirements
Module: seg7_scan_controller

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, meaning CLK_IN cycles per digit slot.
REQ-002 Parameter BLANK_CYCLES, default 1000, meaning leading anti-ghost cycles per slot with all anodes off.
REQ-003 CLK_IN  input  1  sole clock; all state changes on its rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-high.
REQ-005 DATA_IN  input  16  four hex nibbles; DATA_IN[3:0] is digit 0 (rightmost).
REQ-006 DP_IN  input  4  decimal point per digit, 1 = lit.
REQ-007 BLANK_IN  input  4  per-digit blank, 1 = digit dark.
REQ-008 LOAD  input  1  one-cycle strobe; captures DATA_IN, DP_IN and BLANK_IN.
REQ-009 LOAD_ACK  output  1  one-cycle pulse when staged data is committed to display.
REQ-010 AN  output  4  anode enables, active-low, AN[i] = digit i.
REQ-011 SEG  output  7  segments, active-low, SEG[0] = a … SEG[6] = g.
REQ-012 DP  output  1  decimal point, active-low.
REQ-013 FRAME_TICK  output  1  one-cycle pulse at each frame boundary.

Function
REQ-014 Prescaler counts 0..REFRESH_DIV-1 and wraps; the wrap cycle is the slot boundary.
REQ-015 Slot FSM has two states: BLANK while count < BLANK_CYCLES, DRIVE otherwise.
REQ-016 Digit index 0..3 advances at each slot boundary; the 3->0 step is the frame boundary.
REQ-017 In BLANK: AN = 4'b1111, SEG = 7'h7F, DP = 1.
REQ-018 In DRIVE: only AN[idx] = 0, SEG = decode(display nibble idx), DP = ~dp[idx]; a blanked digit keeps AN = 4'b1111.
REQ-019 AN, SEG and DP are registered: one cycle latency after the state/count that selects them.
REQ-020 Decode table: 0 -> 7'b1000000, 1 -> 7'b1111001, 8 -> 7'b0000000, A -> 7'b0001000, F -> 7'b0001110; full standard hex font for all 16 codes.
REQ-021 LOAD writes the staging registers and sets pending; a second LOAD before commit overwrites staging (latest wins).
REQ-022 At the frame boundary with pending set: display <= staging, pending cleared, LOAD_ACK = 1 for that cycle.
REQ-023 LOAD coincident with a frame boundary: commit uses the pre-LOAD staging value, new value is staged, pending stays set, commit occurs at the next frame.
REQ-024 FRAME_TICK pulses at every frame boundary regardless of pending.
REQ-025 Display never changes mid-frame; no partial-frame tearing.
REQ-026 Integrator guarantees 1 <= BLANK_CYCLES < REFRESH_DIV; a violation fails at elaboration.

Reset
REQ-027 RST asserted immediately forces AN = 4'b1111, SEG = 7'h7F, DP = 1, LOAD_ACK = 0, FRAME_TICK = 0.
REQ-028 RST clears prescaler, digit index (0), state (BLANK), staging, display and pending.
REQ-029 Reset mid-slot or mid-pending discards the pending load; no LOAD_ACK follows.
REQ-030 After RST deasserts, the first rising edge starts slot 0 in BLANK.

Structure
REQ-031 Shared package seg7_pkg holds NUM_DIGITS = 4, FSM state encoding and the 16-entry segment font constants.
REQ-032 Sub-module hex_to_7seg: combinational nibble-to-active-low-segment decoder, instantiated once on the muxed nibble.

Verification (REFRESH_DIV = 8, BLANK_CYCLES = 2)
REQ-033 Reset then LOAD DATA_IN = 16'h1234, DP_IN = 0, BLANK_IN = 0 -> LOAD_ACK at first frame boundary; next frame digit 0 shows SEG = 7'b0011001 ("4") with AN = 4'b1110 for 6 cycles after 2 dark cycles.
REQ-034 Free run -> AN sequence 1110, 1101, 1011, 0111 every 8 cycles; FRAME_TICK every 32 cycles; AN = 1111 for cycles 0-1 (+1 latency) of each slot.
REQ-035 LOAD 16'hAAAA then 16'h8888 before the boundary -> single LOAD_ACK; all digits show 7'b0000000.
REQ-036 LOAD 16'hFFFF on the exact frame-boundary cycle -> no commit of FFFF that frame; LOAD_ACK and commit one frame (32 cycles) later.
REQ-037 BLANK_IN = 4'b0101, DP_IN = 4'b0010 -> AN never 1110 or 1011; DP = 0 only while AN = 1101.
REQ-038 Assert RST mid-DRIVE with a pending load -> outputs dark within the same cycle; no LOAD_ACK after release; display shows 0000.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared definitions for the 4-digit seven-segment scan controller:
// digit count, slot FSM encoding, display record and hex font.
package seg7_pkg;

    localparam int NUM_DIGITS = 4;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } slot_state_e;

    // One complete display image: nibbles, decimal points, blanks.
    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  dp;
        logic [3:0]  blank;
    } frame_t;

    // Active-low segments, bit 0 = a ... bit 6 = g.
    localparam logic [6:0] SEG_OFF = 7'h7F;

    localparam logic [6:0] SEG_FONT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to active-low seven-segment decoder.
// Ports: nibble_i (4-bit code), seg_n_o (segments a..g, active-low).
module hex_to_7seg
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_n_o
);

    always_comb begin
        seg_n_o = SEG_FONT[nibble_i];
    end

endmodule

// File: rtl/seg7_scan_controller.sv
// Time-multiplexed driver for a 4-digit common-anode hex display with
// per-slot anti-ghost blanking and frame-synchronous double buffering.
// Ports: CLK_IN/RST (async active-high), DATA_IN/DP_IN/BLANK_IN with
// LOAD strobe in; LOAD_ACK, AN, SEG, DP (active-low), FRAME_TICK out.
module seg7_scan_controller
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        CLK_IN,
    input  logic        RST,
    input  logic [15:0] DATA_IN,
    input  logic [3:0]  DP_IN,
    input  logic [3:0]  BLANK_IN,
    input  logic        LOAD,
    output logic        LOAD_ACK,
    output logic [3:0]  AN,
    output logic [6:0]  SEG,
    output logic        DP,
    output logic        FRAME_TICK
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);
    localparam logic [1:0]    IDX_LAST  = 2'(NUM_DIGITS - 1);

    generate
        if (BLANK_CYCLES < 1 || BLANK_CYCLES >= REFRESH_DIV) begin : g_bad_cfg
            $error("seg7_scan_controller: need 1 <= BLANK_CYCLES < REFRESH_DIV");
        end
    endgenerate

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    slot_state_e   state_q, state_d;
    frame_t        stage_q, stage_d;
    frame_t        disp_q, disp_d;
    logic          pending_q, pending_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;

    logic          slot_end;
    logic          frame_end;
    logic [3:0]    nibble;
    logic [6:0]    seg_dec;

    // Scan timing and load/commit bookkeeping.
    always_comb begin
        slot_end  = (cnt_q == CNT_LAST);
        frame_end = slot_end && (idx_q == IDX_LAST);
        cnt_d     = slot_end ? '0 : cnt_q + CW'(1);
        idx_d     = slot_end ? idx_q + 2'd1 : idx_q;

        stage_d = stage_q;
        if (LOAD) begin
            stage_d = '{data: DATA_IN, dp: DP_IN, blank: BLANK_IN};
        end

        // Commit takes the staging value as it stood before any
        // coincident LOAD; that LOAD keeps pending set for next frame.
        disp_d = disp_q;
        if (frame_end && pending_q) begin
            disp_d = stage_q;
        end
        pending_d = LOAD | (pending_q & ~frame_end);
    end

    // Slot FSM: state tracks the count it will be paired with.
    always_comb begin
        state_d = ST_DRIVE;
        if (cnt_d < CNT_BLANK) begin
            state_d = ST_BLANK;
        end
    end

    always_comb begin
        nibble = disp_q.data[{idx_q, 2'b00} +: 4];
    end

    hex_to_7seg u_dec (
        .nibble_i (nibble),
        .seg_n_o  (seg_dec)
    );

    always_comb begin
        an_d  = 4'b1111;
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
        if (state_q == ST_DRIVE && !disp_q.blank[idx_q]) begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = seg_dec;
            dp_d  = ~disp_q.dp[idx_q];
        end
    end

    always_ff @(posedge CLK_IN or posedge RST) begin
        if (RST) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            state_q   <= ST_BLANK;
            stage_q   <= '0;
            disp_q    <= '0;
            pending_q <= 1'b0;
            an_q      <= 4'b1111;
            seg_q     <= SEG_OFF;
            dp_q      <= 1'b1;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            state_q   <= state_d;
            stage_q   <= stage_d;
            disp_q    <= disp_d;
            pending_q <= pending_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
        end
    end

    assign AN         = an_q;
    assign SEG        = seg_q;
    assign DP         = dp_q;
    assign FRAME_TICK = frame_end;
    assign LOAD_ACK   = frame_end & pending_q;

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Directed self-checking bench for seg7_scan_controller with
// REFRESH_DIV = 8 and BLANK_CYCLES = 2 (32-cycle frames).
module tb_seg7_scan_controller;

    localparam int RD = 8;
    localparam int BC = 2;
    localparam int FRAME = RD * 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load = 1'b0;
    logic [15:0] data_in = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blank_in = '0;
    logic        load_ack;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_tick;

    always #5 clk = ~clk;

    seg7_scan_controller #(
        .REFRESH_DIV  (RD),
        .BLANK_CYCLES (BC)
    ) dut (
        .CLK_IN     (clk),
        .RST        (rst),
        .DATA_IN    (data_in),
        .DP_IN      (dp_in),
        .BLANK_IN   (blank_in),
        .LOAD       (load),
        .LOAD_ACK   (load_ack),
        .AN         (an),
        .SEG        (seg),
        .DP         (dp),
        .FRAME_TICK (frame_tick)
    );

    int k;
    int n_chk;
    int n_fail;

    typedef struct {
        string       name;
        logic [15:0] data;
        logic [3:0]  dpm;
        logic [3:0]  blk;
        logic [27:0] segs;
    } vec_t;

    vec_t vecs [5];

    localparam logic [27:0] ZERO4 = {4{7'h40}};
    localparam logic [27:0] S1234 = {7'h79, 7'h24, 7'h30, 7'h19};

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock; LOAD is a single-cycle strobe so drop it after the edge.
    task automatic tick;
        @(posedge clk);
        #1;
        k++;
        load = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #2;
        chk({tag, " rst an"}, an, 4'b1111);
        chk({tag, " rst seg"}, seg, 7'h7F);
        chk({tag, " rst dp"}, dp, 1'b1);
        chk({tag, " rst ack"}, load_ack, 1'b0);
        chk({tag, " rst tick"}, frame_tick, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        k = 0;
    endtask

    // Checks one 32-cycle frame; entry requires k % 32 == 0.  Output
    // seen after edge k reflects the scan position of cycle k-1.
    task automatic check_frame(input string tag, input logic [27:0] segs,
                               input logic [3:0] dpm, input logic [3:0] blk,
                               input bit ack_end);
        int p, c, s;
        logic [3:0] an_e;
        logic [6:0] seg_e;
        logic dp_e;
        logic bnd;
        logic [3:0] one;
        one = 4'b0001;
        for (int i = 0; i < FRAME; i++) begin
            tick();
            p = k - 1;
            c = p % RD;
            s = (p / RD) % 4;
            an_e = 4'b1111;
            seg_e = 7'h7F;
            dp_e = 1'b1;
            if (c >= BC && !blk[s]) begin
                an_e = ~(one << s);
                seg_e = segs[s*7 +: 7];
                dp_e = ~dpm[s];
            end
            bnd = ((k % FRAME) == FRAME - 1);
            chk($sformatf("%s an k=%0d", tag, k), an, an_e);
            chk($sformatf("%s seg k=%0d", tag, k), seg, seg_e);
            chk($sformatf("%s dp k=%0d", tag, k), dp, dp_e);
            chk($sformatf("%s tick k=%0d", tag, k), frame_tick, bnd);
            chk($sformatf("%s ack k=%0d", tag, k), load_ack,
                bnd & ack_end);
        end
    endtask

    initial begin
        int acks;
        n_chk = 0;
        n_fail = 0;
        k = 0;

        vecs[0] = '{"v1234", 16'h1234, 4'b0000, 4'b0000, S1234};
        vecs[1] = '{"v8F0A", 16'h8F0A, 4'b1001, 4'b0000,
                    {7'h00, 7'h0E, 7'h40, 7'h08}};
        vecs[2] = '{"vblank", 16'h5678, 4'b0010, 4'b0101,
                    {7'h12, 7'h7F, 7'h78, 7'h7F}};
        vecs[3] = '{"v9BCD", 16'h9BCD, 4'b0100, 4'b0000,
                    {7'h10, 7'h03, 7'h46, 7'h21}};
        vecs[4] = '{"vE2E3", 16'hE2E3, 4'b1111, 4'b1000,
                    {7'h7F, 7'h24, 7'h06, 7'h30}};

        #1;
        do_reset("init");

        // Load in slot 0, commit at first boundary, shown next frame.
        for (int v = 0; v < 5; v++) begin
            do_reset(vecs[v].name);
            data_in = vecs[v].data;
            dp_in = vecs[v].dpm;
            blank_in = vecs[v].blk;
            load = 1'b1;
            check_frame({vecs[v].name, "_f1"}, ZERO4, 4'b0, 4'b0, 1'b1);
            check_frame(vecs[v].name, vecs[v].segs, vecs[v].dpm,
                        vecs[v].blk, 1'b0);
        end
        dp_in = '0;
        blank_in = '0;

        // Two loads before the boundary: latest wins, one acknowledge.
        do_reset("dbl");
        data_in = 16'hAAAA;
        load = 1'b1;
        tick();
        data_in = 16'h8888;
        load = 1'b1;
        tick();
        acks = 0;
        while (k < FRAME) begin
            tick();
            if (load_ack) acks++;
        end
        chk("dbl ack count", acks, 1);
        check_frame("dbl", {4{7'h00}}, 4'b0, 4'b0, 1'b0);

        // LOAD on the boundary cycle itself is deferred one frame.
        do_reset("bnd");
        data_in = 16'h1234;
        load = 1'b1;
        tick();
        while (k < FRAME - 1) tick();
        chk("bnd tick", frame_tick, 1'b1);
        chk("bnd ack", load_ack, 1'b1);
        data_in = 16'hFFFF;
        load = 1'b1;
        tick();
        check_frame("bnd_old", S1234, 4'b0, 4'b0, 1'b1);
        check_frame("bnd_new", {4{7'h0E}}, 4'b0, 4'b0, 1'b0);

        // Reset while driving with a load pending.
        do_reset("mid");
        data_in = 16'h1234;
        load = 1'b1;
        tick();
        while (k < 12) tick();
        chk("mid pre an", an, 4'b1101);
        chk("mid pre seg", seg, 7'h40);
        do_reset("mid");
        check_frame("post_rst", ZERO4, 4'b0, 4'b0, 1'b0);
        check_frame("post_rst2", ZERO4, 4'b0, 4'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
